// File: rtl/lf_edge_modulator.sv
// LF transmit modulator: serializes bytes MSB-first with NRZ, Manchester or biphase
// coding at a programmable bit period, mirroring the edge detector's toggle output.
module lf_edge_modulator #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] bit_period,
    input  logic [1:0]       encoding,
    input  logic             invert,
    input  logic [7:0]       tx_data,
    input  logic             tx_last,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             mod_out,
    output logic             edge_toggle,
    output logic             busy,
    output logic             underrun
);

    typedef enum logic [1:0] {IDLE, FIRST_HALF, SECOND_HALF} state_t;

    localparam logic [1:0]       ENC_NRZ = 2'b00;
    localparam logic [1:0]       ENC_MAN = 2'b01;
    localparam logic [1:0]       ENC_BIP = 2'b10;
    localparam logic [DIV_W-1:0] MIN_P   = DIV_W'(4);
    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

    state_t           state_reg, state_next;
    logic [7:0]       hold_data_reg, hold_data_next;
    logic             hold_last_reg, hold_last_next;
    logic             hold_full_reg, hold_full_next;
    logic [7:0]       shift_reg, shift_next;
    logic             cur_last_reg, cur_last_next;
    logic [2:0]       bit_cnt_reg, bit_cnt_next;
    logic [DIV_W-1:0] half_cnt_reg, half_cnt_next;
    logic [DIV_W-1:0] h1_reg, h1_next;
    logic [DIV_W-1:0] h2_reg, h2_next;
    logic [1:0]       enc_reg, enc_next;
    logic             inv_reg, inv_next;
    logic             level_reg, level_next;
    logic             mod_out_reg, mod_out_next;
    logic             edge_toggle_reg, edge_toggle_next;
    logic             underrun_reg, underrun_next;

    logic [DIV_W-1:0] p_clamped, h1_in, h2_in;
    logic [1:0]       enc_in;
    logic             accept, consume;

    // Raw (pre-inversion) level for one half of a bit; cur is the level currently driven.
    function automatic logic half_level(input logic [1:0] enc, input logic second,
                                        input logic b, input logic cur);
        case (enc)
            ENC_MAN: return second ? ~b : b;
            ENC_BIP: return second ? (b ? cur : ~cur) : ~cur;
            default: return b;
        endcase
    endfunction

    assign p_clamped = (bit_period < MIN_P) ? MIN_P : bit_period;
    assign h1_in     = p_clamped >> 1;
    assign h2_in     = p_clamped - h1_in;
    assign enc_in    = (encoding == 2'b11) ? ENC_NRZ : encoding;
    assign accept    = tx_valid & ~hold_full_reg;

    always_comb begin
        state_next     = state_reg;
        hold_data_next = hold_data_reg;
        hold_last_next = hold_last_reg;
        shift_next     = shift_reg;
        cur_last_next  = cur_last_reg;
        bit_cnt_next   = bit_cnt_reg;
        half_cnt_next  = half_cnt_reg;
        h1_next        = h1_reg;
        h2_next        = h2_reg;
        enc_next       = enc_reg;
        inv_next       = inv_reg;
        level_next     = level_reg;
        mod_out_next   = mod_out_reg;
        underrun_next  = 1'b0;
        consume        = 1'b0;

        case (state_reg)
            IDLE: begin
                level_next   = 1'b0;
                mod_out_next = invert;
                if (hold_full_reg) begin
                    // Frame configuration is frozen here until the frame ends.
                    consume       = 1'b1;
                    h1_next       = h1_in;
                    h2_next       = h2_in;
                    enc_next      = enc_in;
                    inv_next      = invert;
                    shift_next    = hold_data_reg;
                    cur_last_next = hold_last_reg;
                    bit_cnt_next  = 3'd0;
                    half_cnt_next = h1_in - ONE;
                    level_next    = half_level(enc_in, 1'b0, hold_data_reg[7], 1'b0);
                    mod_out_next  = level_next ^ invert;
                    state_next    = FIRST_HALF;
                end
            end
            FIRST_HALF: begin
                if (half_cnt_reg == '0) begin
                    state_next    = SECOND_HALF;
                    half_cnt_next = h2_reg - ONE;
                    level_next    = half_level(enc_reg, 1'b1, shift_reg[7], level_reg);
                    mod_out_next  = level_next ^ inv_reg;
                end else begin
                    half_cnt_next = half_cnt_reg - ONE;
                end
            end
            SECOND_HALF: begin
                if (half_cnt_reg != '0) begin
                    half_cnt_next = half_cnt_reg - ONE;
                end else if (bit_cnt_reg != 3'd7) begin
                    shift_next    = {shift_reg[6:0], 1'b0};
                    bit_cnt_next  = bit_cnt_reg + 3'd1;
                    state_next    = FIRST_HALF;
                    half_cnt_next = h1_reg - ONE;
                    level_next    = half_level(enc_reg, 1'b0, shift_reg[6], level_reg);
                    mod_out_next  = level_next ^ inv_reg;
                end else if (hold_full_reg) begin
                    consume       = 1'b1;
                    shift_next    = hold_data_reg;
                    cur_last_next = hold_last_reg;
                    bit_cnt_next  = 3'd0;
                    state_next    = FIRST_HALF;
                    half_cnt_next = h1_reg - ONE;
                    level_next    = half_level(enc_reg, 1'b0, hold_data_reg[7], level_reg);
                    mod_out_next  = level_next ^ inv_reg;
                end else begin
                    state_next    = IDLE;
                    level_next    = 1'b0;
                    mod_out_next  = invert;
                    underrun_next = ~cur_last_reg;
                end
            end
            default: state_next = IDLE;
        endcase

        if (accept) begin
            hold_data_next = tx_data;
            hold_last_next = tx_last;
        end
        hold_full_next   = (hold_full_reg & ~consume) | accept;
        edge_toggle_next = edge_toggle_reg ^ (mod_out_next != mod_out_reg);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            hold_data_reg   <= '0;
            hold_last_reg   <= 1'b0;
            hold_full_reg   <= 1'b0;
            shift_reg       <= '0;
            cur_last_reg    <= 1'b0;
            bit_cnt_reg     <= '0;
            half_cnt_reg    <= '0;
            h1_reg          <= '0;
            h2_reg          <= '0;
            enc_reg         <= ENC_NRZ;
            inv_reg         <= 1'b0;
            level_reg       <= 1'b0;
            mod_out_reg     <= 1'b0;
            edge_toggle_reg <= 1'b0;
            underrun_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            hold_data_reg   <= hold_data_next;
            hold_last_reg   <= hold_last_next;
            hold_full_reg   <= hold_full_next;
            shift_reg       <= shift_next;
            cur_last_reg    <= cur_last_next;
            bit_cnt_reg     <= bit_cnt_next;
            half_cnt_reg    <= half_cnt_next;
            h1_reg          <= h1_next;
            h2_reg          <= h2_next;
            enc_reg         <= enc_next;
            inv_reg         <= inv_next;
            level_reg       <= level_next;
            mod_out_reg     <= mod_out_next;
            edge_toggle_reg <= edge_toggle_next;
            underrun_reg    <= underrun_next;
        end
    end

    assign tx_ready    = ~hold_full_reg;
    assign busy        = (state_reg != IDLE);
    assign mod_out     = mod_out_reg;
    assign edge_toggle = edge_toggle_reg;
    assign underrun    = underrun_reg;

endmodule

// File: tb/tb_lf_edge_modulator.sv
// Directed bench for lf_edge_modulator: per-cycle waveform, busy, toggle-count and
// underrun checks against hand-written expected level sequences.
module tb_lf_edge_modulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] bit_period = 16'd8;
    logic [1:0]  encoding = 2'b00;
    logic        invert = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_last = 1'b0;
    logic        tx_valid = 1'b0;
    logic        tx_ready, mod_out, edge_toggle, busy, underrun;

    int checks = 0;
    int failures = 0;
    bit exp_q[$];
    logic prev_et;
    int toggles;

    lf_edge_modulator #(.DIV_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bit_period(bit_period), .encoding(encoding),
        .invert(invert), .tx_data(tx_data), .tx_last(tx_last), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .mod_out(mod_out), .edge_toggle(edge_toggle),
        .busy(busy), .underrun(underrun)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic add_level(input bit lvl, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(lvl);
    endtask

    // Offers one byte at a negedge; it is accepted at the following posedge (E0).
    task automatic start_frame(input logic [7:0] d, input logic l);
        @(negedge clk);
        tx_data = d; tx_last = l; tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #3;
        checks++; if (mod_out !== 1'b0) begin failures++; $display("FAIL reset_mod_out got=%b want=0", mod_out); end
        checks++; if (edge_toggle !== 1'b0) begin failures++; $display("FAIL reset_edge_toggle got=%b want=0", edge_toggle); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL reset_tx_ready got=%b want=1", tx_ready); end
        checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL reset_underrun got=%b want=0", underrun); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_manchester;
        logic [15:0] pat;
        pat = 16'b1001100101100110;
        encoding = 2'b01; bit_period = 16'd8; invert = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 16; i++) add_level(pat[15-i], 4);
        start_frame(8'hA5, 1'b1);
        @(negedge clk);
        checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL man_ready_after_accept got=%b want=0", tx_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL man_busy_before_load got=%b want=0", busy); end
        prev_et = edge_toggle; toggles = 0;
        for (int n = 0; n < exp_q.size(); n++) begin
            @(negedge clk);
            if (edge_toggle !== prev_et) toggles++;
            prev_et = edge_toggle;
            checks++; if (mod_out !== exp_q[n]) begin failures++; $display("FAIL man_mod cycle=%0d got=%b want=%b", n, mod_out, exp_q[n]); end
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL man_busy cycle=%0d got=%b want=1", n, busy); end
            checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL man_underrun cycle=%0d got=%b want=0", n, underrun); end
            if (n == 0) begin
                checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL man_ready_after_load got=%b want=1", tx_ready); end
            end
        end
        @(negedge clk);
        if (edge_toggle !== prev_et) toggles++;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL man_busy_end got=%b want=0", busy); end
        checks++; if (mod_out !== 1'b0) begin failures++; $display("FAIL man_mod_end got=%b want=0", mod_out); end
        checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL man_underrun_end got=%b want=0", underrun); end
        checks++; if (toggles != 10) begin failures++; $display("FAIL man_toggles got=%0d want=10", toggles); end
        $display("test_manchester done toggles=%0d", toggles);
    endtask

    task automatic test_back_to_back;
        encoding = 2'b00; bit_period = 16'd6; invert = 1'b0;
        exp_q.delete();
        add_level(1'b1, 24); add_level(1'b0, 48); add_level(1'b1, 24);
        start_frame(8'hF0, 1'b0);
        @(negedge clk);
        for (int n = 0; n < exp_q.size(); n++) begin
            @(negedge clk);
            if (n == 3) begin
                checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_held got=%b want=0", tx_ready); end
                tx_valid = 1'b0;
            end
            if (n == 2) begin
                tx_data = 8'h0F; tx_last = 1'b1; tx_valid = 1'b1;
            end
            checks++; if (mod_out !== exp_q[n]) begin failures++; $display("FAIL b2b_mod cycle=%0d got=%b want=%b", n, mod_out, exp_q[n]); end
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy cycle=%0d got=%b want=1", n, busy); end
            checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL b2b_underrun cycle=%0d got=%b want=0", n, underrun); end
        end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_busy_end got=%b want=0", busy); end
        checks++; if (mod_out !== 1'b0) begin failures++; $display("FAIL b2b_mod_end got=%b want=0", mod_out); end
        $display("test_back_to_back done");
    endtask

    task automatic test_biphase(input bit inv);
        encoding = 2'b10; bit_period = 16'd8; invert = inv;
        @(negedge clk); @(negedge clk);
        checks++; if (mod_out !== inv) begin failures++; $display("FAIL bip_idle inv=%0d got=%b want=%b", inv, mod_out, inv); end
        exp_q.delete();
        for (int i = 0; i < 16; i++) add_level(((i % 2) == 0) ^ inv, 4);
        start_frame(8'h00, 1'b1);
        @(negedge clk);
        prev_et = edge_toggle; toggles = 0;
        for (int n = 0; n < exp_q.size(); n++) begin
            @(negedge clk);
            if (edge_toggle !== prev_et) toggles++;
            prev_et = edge_toggle;
            checks++; if (mod_out !== exp_q[n]) begin failures++; $display("FAIL bip_mod inv=%0d cycle=%0d got=%b want=%b", inv, n, mod_out, exp_q[n]); end
        end
        @(negedge clk);
        if (edge_toggle !== prev_et) toggles++;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bip_busy_end inv=%0d got=%b want=0", inv, busy); end
        checks++; if (mod_out !== inv) begin failures++; $display("FAIL bip_mod_end inv=%0d got=%b want=%b", inv, mod_out, inv); end
        checks++; if (toggles != 16) begin failures++; $display("FAIL bip_toggles inv=%0d got=%0d want=16", inv, toggles); end
        invert = 1'b0;
        @(negedge clk);
        $display("test_biphase inv=%0d done toggles=%0d", inv, toggles);
    endtask

    task automatic test_underrun;
        logic [15:0] pat;
        pat = 16'b0110011001100110;
        encoding = 2'b01; bit_period = 16'd4; invert = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 16; i++) add_level(pat[15-i], 2);
        start_frame(8'h55, 1'b0);
        @(negedge clk);
        for (int n = 0; n < exp_q.size(); n++) begin
            @(negedge clk);
            checks++; if (mod_out !== exp_q[n]) begin failures++; $display("FAIL udr_mod cycle=%0d got=%b want=%b", n, mod_out, exp_q[n]); end
            checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL udr_early cycle=%0d got=%b want=0", n, underrun); end
        end
        @(negedge clk);
        checks++; if (underrun !== 1'b1) begin failures++; $display("FAIL udr_pulse got=%b want=1", underrun); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL udr_busy got=%b want=0", busy); end
        checks++; if (mod_out !== 1'b0) begin failures++; $display("FAIL udr_mod_idle got=%b want=0", mod_out); end
        @(negedge clk);
        checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL udr_single got=%b want=0", underrun); end
        $display("test_underrun done");
    endtask

    task automatic test_clamp(input logic [15:0] p, input int h1, input int h2);
        logic [15:0] pat;
        pat = 16'b1001100101100110;
        encoding = 2'b01; bit_period = p; invert = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 16; i++) add_level(pat[15-i], ((i % 2) == 0) ? h1 : h2);
        start_frame(8'hA5, 1'b1);
        @(negedge clk);
        for (int n = 0; n < exp_q.size(); n++) begin
            @(negedge clk);
            if (n == 5) bit_period = 16'd8;
            checks++; if (mod_out !== exp_q[n]) begin failures++; $display("FAIL clamp_mod p=%0d cycle=%0d got=%b want=%b", p, n, mod_out, exp_q[n]); end
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL clamp_busy p=%0d cycle=%0d got=%b want=1", p, n, busy); end
        end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL clamp_len p=%0d busy=%b want=0 after %0d cycles", p, busy, exp_q.size()); end
        $display("test_clamp p=%0d done", p);
    endtask

    task automatic test_reset_mid_frame;
        encoding = 2'b00; bit_period = 16'd4; invert = 1'b0;
        start_frame(8'hAA, 1'b0);
        @(negedge clk);
        for (int n = 0; n < 13; n++) begin
            @(negedge clk);
            if (n == 1) begin tx_data = 8'h55; tx_last = 1'b1; tx_valid = 1'b1; end
            if (n == 2) tx_valid = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        checks++; if (mod_out !== 1'b0) begin failures++; $display("FAIL rstmid_mod got=%b want=0", mod_out); end
        checks++; if (edge_toggle !== 1'b0) begin failures++; $display("FAIL rstmid_edge got=%b want=0", edge_toggle); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b want=0", busy); end
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%b want=1", tx_ready); end
        checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL rstmid_underrun got=%b want=0", underrun); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_hold_dropped busy=%b want=0", busy); end
        exp_q.delete();
        add_level(1'b1, 4); add_level(1'b0, 24); add_level(1'b1, 4);
        start_frame(8'h81, 1'b1);
        @(negedge clk);
        for (int n = 0; n < exp_q.size(); n++) begin
            @(negedge clk);
            checks++; if (mod_out !== exp_q[n]) begin failures++; $display("FAIL rstmid_next_mod cycle=%0d got=%b want=%b", n, mod_out, exp_q[n]); end
        end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_next_busy got=%b want=0", busy); end
        checks++; if (mod_out !== 1'b0) begin failures++; $display("FAIL rstmid_next_mod_end got=%b want=0", mod_out); end
        $display("test_reset_mid_frame done");
    endtask

    initial begin
        test_reset();
        test_manchester();
        test_back_to_back();
        test_biphase(1'b0);
        test_biphase(1'b1);
        test_underrun();
        test_clamp(16'd1, 2, 2);
        test_clamp(16'd5, 2, 3);
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lf_edge_modulator.md
# lf_edge_modulator

Transmit-side counterpart to the LF edge detector. It takes bytes from the ARM-side byte interface and serializes them MSB-first, with NRZ, Manchester or biphase line coding at a programmable bit period. It drives the LF modulation control line and an edge-toggle strobe whose form matches the detector's output, so an encoder/decoder loopback compares like with like. It sits between the SSP byte path and the LF antenna-drive mux.

## Interface
- DIV_W, 16, width of bit_period

- clk  in  1  main FPGA clock; all logic on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- bit_period  in  DIV_W  clk cycles per bit; values <4 are treated as 4
- encoding  in  2  00 NRZ, 01 Manchester, 10 biphase, 11 treated as NRZ
- invert  in  1  inverts mod_out and the idle level
- tx_data  in  8  byte to send
- tx_last  in  1  qualifies tx_data as the final byte of the frame
- tx_valid  in  1  tx_data/tx_last present
- tx_ready  out  1  holding register empty; accept on tx_valid & tx_ready
- mod_out  out  1  registered modulation level
- edge_toggle  out  1  toggles on every cycle in which mod_out changes value
- busy  out  1  frame in progress
- underrun  out  1  one-cycle pulse when a non-last byte finishes with no successor

## Operation
- Buffering:
  - One holding register (data + last flag) plus an 8-bit shift register.
  - tx_ready = holding register empty, including in IDLE.
- FSM states: IDLE, FIRST_HALF, SECOND_HALF.
- IDLE:
  - mod_out = invert.
  - When the holding register is full: latch bit_period (clamped), encoding and invert for the whole frame; move the byte into the shifter; go to FIRST_HALF.
  - Changes to these config inputs during a frame are ignored.
- Half lengths: h1 = P>>1 and h2 = P−h1, where P is the clamped period. Example: P=5 gives h1=2, h2=3.
- Levels per bit b, before inversion:
  - NRZ: b for both halves.
  - Manchester: 1 → (1,0); 0 → (0,1).
  - Biphase: toggle the level at the start of every bit; toggle again at mid-bit when b=0.
  - Biphase reference level at frame start = the idle level.
- End of SECOND_HALF of bit 0 (LSB position):
  - If the holding register is full, load the shifter from it and continue with FIRST_HALF, with no gap.
  - Else, if the current byte's last flag is set, go to IDLE.
  - Else, pulse underrun and go to IDLE.
- On return to IDLE, mod_out returns to the idle level on the same edge. If that is a change, edge_toggle toggles.
- busy = (state != IDLE).
- Holding register fill: a new byte may be accepted any time the holding register is empty, including during the current byte.

## Timing
- Reset values: mod_out=0, edge_toggle=0, busy=0, tx_ready=1, underrun=0, state IDLE, holding register empty.
- Reset mid-frame aborts immediately and drops the shifter and holding contents.
- Latency, with accept at edge E0:
  - tx_ready=0 after E0.
  - Shifter load and busy=1 at E1.
  - First bit's first-half level on mod_out at E1.
  - tx_ready returns to 1 at E1.
- Each half lasts exactly h1 or h2 cycles on mod_out.
- One byte lasts exactly 8·P cycles.
- busy falls on the edge that ends the last bit; underrun pulses on that same edge.
- Simultaneous accept and shifter reload from the holding register in one cycle: the reload takes the old holding contents and the accept writes the new byte. Nothing is lost.
- tx_valid with tx_ready=0 has no effect; tx_data must be held stable by the source.

## Test plan
- Manchester, P=8, single byte 0xA5 with last=1:
  - mod_out half-levels 1,0,0,1,1,0,0,1,0,1,1,0,0,1,1,0, each 4 cycles.
  - busy high for 64 cycles.
  - edge_toggle toggles 10 times.
  - underrun stays 0.
- NRZ, P=6, bytes 0xF0 then 0x0F (last=1) back-to-back:
  - mod_out high 24, low 48, high 24 cycles, with no gap.
  - Returns to 0; total busy 96 cycles.
- Biphase, P=8, 0x00 (last=1), invert=0:
  - 16 toggles in 64 cycles with 4-cycle alternating levels, ending at 0.
  - Repeat with invert=1: mod_out idles at 1 and the waveform is complemented.
- Underrun, Manchester, P=4, 0x55 with last=0 and no further byte:
  - underrun pulses once at cycle 32 after load.
  - busy falls on the same edge; mod_out returns to the idle level.
- Period clamp and odd split:
  - P=1 gives 2/2-cycle halves (byte = 32 cycles).
  - P=5 gives 2/3-cycle halves (byte = 40 cycles).
  - Changing bit_period mid-frame has no effect until the next frame.
- Reset mid-frame:
  - Assert rst_n low at bit 3 of a two-byte frame.
  - All outputs reach their reset values asynchronously, and the next frame starts clean.
